// File: rtl/mic_sound_detector_pkg.sv
// Shared state encodings and default timing for the sound detector and the mic alarm stage.
package mic_sound_detector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        ACTIVE  = 2'd2,
        HOLDOFF = 2'd3
    } mic_state_e;

    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_DEBOUNCE_CYC  = 50000;
    localparam int unsigned DEF_HOLDOFF_CYC   = 25000000;
    localparam int unsigned DEF_DCLAP_WIN_CYC = 50000000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mic_sound_detector_if.sv
// Sensor input and conditioned outputs of the sound detector.
interface mic_sound_detector_if;
    logic       mic_raw;
    logic       enable;
    logic       mic_clean;
    logic       sound_evt;
    logic       double_clap;
    logic [7:0] evt_count;

    modport master (
        output mic_raw, enable,
        input  mic_clean, sound_evt, double_clap, evt_count
    );

    modport slave (
        input  mic_raw, enable,
        output mic_clean, sound_evt, double_clap, evt_count
    );
endinterface

// File: rtl/mic_sound_detector_sync_ff.sv
// Multi-flop synchronizer for the asynchronous sensor pin.
module mic_sound_detector_sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= {sr_q[STAGES-2:0], d};
        end
    end

    assign q = sr_q[STAGES-1];

endmodule

// File: rtl/mic_sound_detector.sv
// Debounces the sound sensor output and derives sound events, double claps and an event count.
module mic_sound_detector
    import mic_sound_detector_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int unsigned HOLDOFF_CYC   = DEF_HOLDOFF_CYC,
    parameter int unsigned DCLAP_WIN_CYC = DEF_DCLAP_WIN_CYC
) (
    input logic                 clk,
    input logic                 rst,
    mic_sound_detector_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(max_u(DEBOUNCE_CYC, HOLDOFF_CYC)) + 1;
    localparam int unsigned WIN_W = $clog2(DCLAP_WIN_CYC) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [WIN_W-1:0] WIN_LOAD  = WIN_W'(DCLAP_WIN_CYC - 1);

    logic mic_sync;

    mic_sound_detector_sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (bus.mic_raw),
        .q  (mic_sync)
    );

    mic_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             clean_q, clean_d;
    logic             evt_q, evt_d;
    logic             dc_q, dc_d;
    logic [7:0]       count_q, count_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            win_q   <= '0;
            clean_q <= 1'b0;
            evt_q   <= 1'b0;
            dc_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            clean_q <= clean_d;
            evt_q   <= evt_d;
            dc_q    <= dc_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = 1'b0;
        dc_d    = 1'b0;
        win_d   = win_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mic_sync) state_d = QUALIFY;
            end
            QUALIFY: begin
                if (!mic_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    evt_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACTIVE: begin
                // Counts only consecutive low samples; any high sample restarts release.
                if (mic_sync) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HOLDOFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // An event seen while the window still reads nonzero (even its last cycle) is a 2nd clap.
        if (evt_d) begin
            if (win_q != '0) begin
                dc_d  = 1'b1;
                win_d = '0;
            end else begin
                win_d = WIN_LOAD;
            end
        end else if (win_q != '0) begin
            win_d = win_q - 1'b1;
        end

        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            win_d   = '0;
            evt_d   = 1'b0;
            dc_d    = 1'b0;
        end

        clean_d = (state_d == ACTIVE);

        if (evt_d && (count_q != 8'hFF)) count_d = count_q + 8'd1;
    end

    assign bus.mic_clean   = clean_q;
    assign bus.sound_evt   = evt_q;
    assign bus.double_clap = dc_q;
    assign bus.evt_count   = count_q;

endmodule
